// File: rtl/ahb_slave_mem_pkg.sv
// ahb_pkg: shared AHB encodings, responder FSM states and the byte-lane
// strobe helper used by the ahb_slave_mem responder.
package ahb_pkg;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'd0,
    TR_BUSY   = 2'd1,
    TR_NONSEQ = 2'd2,
    TR_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [1:0] {
    RESP_OKAY  = 2'd0,
    RESP_ERROR = 2'd1,
    RESP_RETRY = 2'd2,
    RESP_SPLIT = 2'd3
  } hresp_e;

  typedef enum logic [2:0] {
    SZ_BYTE = 3'd0,
    SZ_HALF = 3'd1,
    SZ_WORD = 3'd2
  } hsize_e;

  typedef enum logic [1:0] {
    ST_ADDR = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } slv_state_e;

  // Little-endian lane select: a byte uses lane addr_lo, a halfword the
  // lane pair {addr_lo[1],x}. Illegal sizes select no lanes.
  function automatic logic [3:0] lane_strobe(input logic [2:0] size,
                                             input logic [1:0] addr_lo);
    logic [3:0] strb;
    strb = 4'b0000;
    case (size)
      SZ_BYTE: strb = 4'b0001 << addr_lo;
      SZ_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/ahb_slave_mem_if.sv
// ahb_slave_mem_if: AHB bus signals between a master driver and the
// ahb_slave_mem responder.
//   master modport: drives hsel/haddr/htrans/hwrite/hsize/hburst/hprot/
//                   hwdata/hready, observes hreadyout/hresp/hrdata
//   slave modport : the mirror image
interface ahb_slave_mem_if #(
  parameter int BUS_WIDTH = 32
);
  logic                 hsel;
  logic [BUS_WIDTH-1:0] haddr;
  logic [1:0]           htrans;
  logic                 hwrite;
  logic [2:0]           hsize;
  logic [2:0]           hburst;
  logic [3:0]           hprot;
  logic [BUS_WIDTH-1:0] hwdata;
  logic                 hready;
  logic                 hreadyout;
  logic [1:0]           hresp;
  logic [BUS_WIDTH-1:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_slave_mem_sram.sv
// ahb_sram: DEPTH x WIDTH storage with per-byte write strobes and an
// asynchronous read port. Contents are deliberately not reset.
//   i_clk    : write clock
//   i_we     : write enable (qualified per byte by i_strb)
//   i_strb   : byte-lane strobes, lane 0 = bits [7:0]
//   i_addr   : word index
//   i_wdata  : write data, bytes on their own lanes
//   o_rdata  : word at i_addr, combinational
module ahb_sram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [3:0]       i_strb,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we && i_strb[i]) begin
        r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB responder backed by an internal word memory. Inserts
// WAIT_STATES wait cycles into every OKAY data phase, answers out-of-range,
// misaligned or oversized transfers with the two-cycle ERROR response.
//   hclk   : clock
//   hreset : asynchronous active-high reset
//   bus    : AHB slave modport (select, address phase, write data in;
//            hreadyout/hresp/hrdata out)
//
// state | meaning
// ------+-------------------------------------------------------------
// ADDR  | ready; completes a pending OKAY data phase, accepts new ones
// WAIT  | OKAY data phase stalled, counting down wait states
// ERR1  | first ERROR cycle, hreadyout low
// ERR2  | second ERROR cycle, hreadyout high, may accept next transfer
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int BUS_WIDTH   = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input logic            hclk,
  input logic            hreset,
  ahb_slave_mem_if.slave bus
);

  localparam int                   AW         = $clog2(MEM_DEPTH);
  localparam logic [BUS_WIDTH-1:0] ADDR_LIMIT = BUS_WIDTH'(MEM_DEPTH * 4);
  localparam logic [3:0]           WAIT_LOAD  =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  slv_state_e      r_state;
  slv_state_e      w_state_nxt;
  logic [3:0]      r_wait_cnt;
  logic [3:0]      w_wait_cnt_nxt;
  logic            r_pend;
  logic            r_write;
  logic [2:0]      r_size;
  logic [AW+1:0]   r_addr;

  logic            w_can_accept;
  logic            w_accept;
  logic            w_err;
  logic            w_complete;
  logic            w_hreadyout;
  hresp_e          w_hresp;
  logic [BUS_WIDTH-1:0] w_mem_rdata;
  logic            w_unused;

  // Only states that drive hreadyout high can take a new address phase.
  assign w_can_accept = (r_state == ST_ADDR) || (r_state == ST_ERR2);
  assign w_accept     = bus.hsel && bus.hready && bus.htrans[1] && w_can_accept;

  assign w_err = (bus.haddr >= ADDR_LIMIT)
              || (bus.hsize > SZ_WORD)
              || ((bus.hsize == SZ_HALF) && bus.haddr[0])
              || ((bus.hsize == SZ_WORD) && (bus.haddr[1:0] != 2'b00));

  // A pending OKAY transfer finishes in ADDR; hready low means some other
  // agent is stalling the bus, so hold everything.
  assign w_complete = (r_state == ST_ADDR) && r_pend && bus.hready;

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_hreadyout    = 1'b1;
    w_hresp        = RESP_OKAY;
    case (r_state)
      ST_ADDR, ST_ERR2: begin
        if (r_state == ST_ERR2) begin
          w_hresp     = RESP_ERROR;
          w_state_nxt = ST_ADDR;
        end
        if (w_accept) begin
          if (w_err) begin
            w_state_nxt = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_state_nxt    = ST_WAIT;
            w_wait_cnt_nxt = WAIT_LOAD;
          end else begin
            w_state_nxt = ST_ADDR;
          end
        end
      end
      ST_WAIT: begin
        w_hreadyout = 1'b0;
        if (r_wait_cnt == 4'd0) begin
          w_state_nxt = ST_ADDR;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt - 4'd1;
        end
      end
      ST_ERR1: begin
        w_hreadyout = 1'b0;
        w_hresp     = RESP_ERROR;
        w_state_nxt = ST_ERR2;
      end
      default: begin
        w_state_nxt = ST_ADDR;
      end
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state    <= ST_ADDR;
      r_wait_cnt <= 4'd0;
      r_pend     <= 1'b0;
      r_write    <= 1'b0;
      r_size     <= 3'd0;
      r_addr     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_complete) begin
        r_pend <= 1'b0;
      end
      if (w_accept) begin
        r_pend  <= !w_err;
        r_write <= bus.hwrite;
        r_size  <= bus.hsize;
        r_addr  <= bus.haddr[AW+1:0];
      end
    end
  end

  ahb_sram #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (BUS_WIDTH),
    .AW    (AW)
  ) u_sram (
    .i_clk   (hclk),
    .i_we    (w_complete && r_write),
    .i_strb  (lane_strobe(r_size, r_addr[1:0])),
    .i_addr  (r_addr[AW+1:2]),
    .i_wdata (bus.hwdata),
    .o_rdata (w_mem_rdata)
  );

  assign bus.hreadyout = w_hreadyout;
  assign bus.hresp     = w_hresp;
  assign bus.hrdata    = ((r_state == ST_ADDR) && r_pend && !r_write)
                       ? w_mem_rdata : '0;

  // Burst type, protection and the sequential hint carry no meaning here.
  assign w_unused = ^{bus.hburst, bus.hprot, bus.htrans[0]};

endmodule

// File: tb/tb_ahb_slave_mem.sv
module tb_ahb_slave_mem;
  import ahb_pkg::*;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic        tb_hsel = 1'b0;
  logic [31:0] tb_haddr = 32'h0;
  logic [1:0]  tb_htrans = 2'd0;
  logic        tb_hwrite = 1'b0;
  logic [2:0]  tb_hsize = 3'd2;
  logic [31:0] tb_hwdata = 32'h0;
  logic        tb_force_nready = 1'b0;
  int          cur = 1;

  logic        cur_rdy;
  logic [1:0]  cur_resp;
  logic [31:0] cur_rdata;
  logic        tb_hready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 hclk = ~hclk;

  ahb_slave_mem_if #(.BUS_WIDTH(32)) u_if0 ();
  ahb_slave_mem_if #(.BUS_WIDTH(32)) u_if1 ();
  ahb_slave_mem_if #(.BUS_WIDTH(32)) u_if2 ();

  ahb_slave_mem #(.BUS_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3))
    u_dut_w3 (.hclk(hclk), .hreset(hreset), .bus(u_if0));
  ahb_slave_mem #(.BUS_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0))
    u_dut_w0 (.hclk(hclk), .hreset(hreset), .bus(u_if1));
  ahb_slave_mem #(.BUS_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2))
    u_dut_w2 (.hclk(hclk), .hreset(hreset), .bus(u_if2));

  // cur picks which responder is addressed and observed.
  always_comb begin
    cur_rdy   = u_if1.hreadyout;
    cur_resp  = u_if1.hresp;
    cur_rdata = u_if1.hrdata;
    case (cur)
      0: begin cur_rdy = u_if0.hreadyout; cur_resp = u_if0.hresp; cur_rdata = u_if0.hrdata; end
      2: begin cur_rdy = u_if2.hreadyout; cur_resp = u_if2.hresp; cur_rdata = u_if2.hrdata; end
      default: ;
    endcase
  end
  assign tb_hready = !tb_force_nready && cur_rdy;

  assign u_if0.hsel = tb_hsel && (cur == 0);
  assign u_if1.hsel = tb_hsel && (cur == 1);
  assign u_if2.hsel = tb_hsel && (cur == 2);
  assign u_if0.haddr = tb_haddr;   assign u_if1.haddr = tb_haddr;   assign u_if2.haddr = tb_haddr;
  assign u_if0.htrans = tb_htrans; assign u_if1.htrans = tb_htrans; assign u_if2.htrans = tb_htrans;
  assign u_if0.hwrite = tb_hwrite; assign u_if1.hwrite = tb_hwrite; assign u_if2.hwrite = tb_hwrite;
  assign u_if0.hsize = tb_hsize;   assign u_if1.hsize = tb_hsize;   assign u_if2.hsize = tb_hsize;
  assign u_if0.hburst = 3'd3;      assign u_if1.hburst = 3'd0;      assign u_if2.hburst = 3'd3;
  assign u_if0.hprot = 4'h3;       assign u_if1.hprot = 4'h3;       assign u_if2.hprot = 4'h3;
  assign u_if0.hwdata = tb_hwdata; assign u_if1.hwdata = tb_hwdata; assign u_if2.hwdata = tb_hwdata;
  assign u_if0.hready = tb_hready; assign u_if1.hready = tb_hready; assign u_if2.hready = tb_hready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  // Single NONSEQ transfer; returns data seen on the completing cycle,
  // whether ERROR appeared and how many hreadyout-low cycles occurred.
  task automatic xfer(input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic err, output int waits);
    int guard;
    err = 1'b0; waits = 0; guard = 0;
    tb_hsel = 1'b1; tb_htrans = 2'd2; tb_hwrite = wr; tb_hsize = sz; tb_haddr = addr;
    step();
    tb_hsel = 1'b0; tb_htrans = 2'd0; tb_hwdata = wd;
    while (!cur_rdy && guard < 40) begin
      if (cur_resp == 2'd1) err = 1'b1;
      waits++; guard++;
      step();
    end
    chk("xfer_bound", 32'(guard >= 40), 32'd0);
    if (cur_resp == 2'd1) err = 1'b1;
    rd = cur_rdata;
    step();
  endtask

  // Called just after the edge that accepted a 2-wait read beat.
  task automatic beat_data(input int b, input logic [31:0] exp,
                           input logic [1:0] ntrans, input logic [31:0] naddr);
    tb_htrans = ntrans; tb_haddr = naddr;
    chk($sformatf("burst%0d_wait1", b), 32'(cur_rdy), 32'd0);
    step();
    chk($sformatf("burst%0d_wait2", b), 32'(cur_rdy), 32'd0);
    step();
    chk($sformatf("burst%0d_ready", b), 32'(cur_rdy), 32'd1);
    chk($sformatf("burst%0d_rdata", b), cur_rdata, exp);
    step();
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[21];

  initial begin
    logic [31:0] rd;
    logic        err;
    int          waits;

    vecs[0]  = '{1'b1, 3'd2, 32'h008, 32'hA5A51234, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 3'd2, 32'h008, 32'h0,        1'b0, 32'hA5A51234};
    vecs[2]  = '{1'b1, 3'd2, 32'h020, 32'h00000000, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 3'd0, 32'h022, 32'h00FF0000, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 3'd1, 32'h020, 32'h0000BEEF, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 3'd2, 32'h020, 32'h0,        1'b0, 32'h00FFBEEF};
    vecs[6]  = '{1'b0, 3'd2, 32'h400, 32'h0,        1'b1, 32'h0};
    vecs[7]  = '{1'b1, 3'd1, 32'h021, 32'h12345678, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 3'd2, 32'h020, 32'h0,        1'b0, 32'h00FFBEEF};
    vecs[9]  = '{1'b1, 3'd2, 32'h3FC, 32'h11223344, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 3'd0, 32'h3FF, 32'h0,        1'b0, 32'h11223344};
    vecs[11] = '{1'b1, 3'd2, 32'h022, 32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[12] = '{1'b0, 3'd3, 32'h000, 32'h0,        1'b1, 32'h0};
    vecs[13] = '{1'b1, 3'd0, 32'h021, 32'h0000AB00, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 3'd2, 32'h020, 32'h0,        1'b0, 32'h00FFABEF};
    vecs[15] = '{1'b1, 3'd2, 32'h000, 32'h0BADF00D, 1'b0, 32'h0};
    vecs[16] = '{1'b1, 3'd2, 32'h400, 32'hDEADDEAD, 1'b1, 32'h0};
    vecs[17] = '{1'b0, 3'd2, 32'h000, 32'h0,        1'b0, 32'h0BADF00D};
    vecs[18] = '{1'b1, 3'd2, 32'h02C, 32'h13579BDF, 1'b0, 32'h0};
    vecs[19] = '{1'b1, 3'd1, 32'h02E, 32'hAAAA0000, 1'b0, 32'h0};
    vecs[20] = '{1'b0, 3'd2, 32'h02C, 32'h0,        1'b0, 32'hAAAA9BDF};

    // Reset values on every responder.
    repeat (2) @(posedge hclk);
    #1;
    for (int k = 0; k < 3; k++) begin
      cur = k;
      #1;
      chk($sformatf("rst%0d_hreadyout", k), 32'(cur_rdy), 32'd1);
      chk($sformatf("rst%0d_hresp", k), 32'(cur_resp), 32'd0);
      chk($sformatf("rst%0d_hrdata", k), cur_rdata, 32'd0);
    end
    @(negedge hclk);
    hreset = 1'b0;
    step();

    // Zero-wait responder: table of single transfers.
    cur = 1;
    for (int i = 0; i < 21; i++) begin
      xfer(vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].wdata, rd, err, waits);
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_waits", i), 32'(waits), vecs[i].exp_err ? 32'd1 : 32'd0);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
    end

    // Pipelined write then read of the same word, no wait states.
    tb_hsel = 1'b1; tb_htrans = 2'd2; tb_hwrite = 1'b1; tb_hsize = 3'd2; tb_haddr = 32'h00C;
    step();
    chk("pipe_wr_ready", 32'(cur_rdy), 32'd1);
    tb_hwdata = 32'h5A5A0F0F; tb_hwrite = 1'b0;
    step();
    chk("pipe_rd_ready", 32'(cur_rdy), 32'd1);
    chk("pipe_rd_data", cur_rdata, 32'h5A5A0F0F);
    tb_hsel = 1'b0; tb_htrans = 2'd0;
    step();

    // Back-to-back errors: second one accepted in the ERR2 cycle.
    tb_hsel = 1'b1; tb_htrans = 2'd2; tb_hwrite = 1'b0; tb_hsize = 3'd2; tb_haddr = 32'h400;
    step();
    tb_htrans = 2'd0;
    chk("err_a1_ready", 32'(cur_rdy), 32'd0);
    chk("err_a1_resp", 32'(cur_resp), 32'd1);
    step();
    chk("err_a2_ready", 32'(cur_rdy), 32'd1);
    chk("err_a2_resp", 32'(cur_resp), 32'd1);
    tb_htrans = 2'd2; tb_hwrite = 1'b1; tb_hsize = 3'd1; tb_haddr = 32'h021;
    step();
    tb_hsel = 1'b0; tb_htrans = 2'd0; tb_hwdata = 32'h55555555;
    chk("err_b1_ready", 32'(cur_rdy), 32'd0);
    chk("err_b1_resp", 32'(cur_resp), 32'd1);
    step();
    chk("err_b2_ready", 32'(cur_rdy), 32'd1);
    chk("err_b2_resp", 32'(cur_resp), 32'd1);
    step();
    chk("err_done_resp", 32'(cur_resp), 32'd0);
    xfer(1'b0, 3'd2, 32'h020, 32'h0, rd, err, waits);
    chk("err_nowrite", rd, 32'h00FFABEF);

    // Selected IDLE: zero-wait OKAY, nothing returned.
    tb_hsel = 1'b1; tb_htrans = 2'd0;
    step();
    chk("idle_ready", 32'(cur_rdy), 32'd1);
    chk("idle_rdata", cur_rdata, 32'd0);
    tb_hsel = 1'b0;
    step();

    // Two-wait responder: INCR4 read with a BUSY between beats 1 and 2.
    cur = 2;
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, 3'd2, 32'h040 + 32'(4 * i), 32'hC0DE0000 + 32'(i), rd, err, waits);
      chk($sformatf("pre%0d_waits", i), 32'(waits), 32'd2);
    end
    tb_hsel = 1'b1; tb_htrans = 2'd2; tb_hwrite = 1'b0; tb_hsize = 3'd2; tb_haddr = 32'h040;
    step();
    beat_data(0, 32'hC0DE0000, 2'd3, 32'h044);
    beat_data(1, 32'hC0DE0001, 2'd1, 32'h048);
    chk("busy_ready", 32'(cur_rdy), 32'd1);
    chk("busy_resp", 32'(cur_resp), 32'd0);
    chk("busy_rdata", cur_rdata, 32'd0);
    tb_htrans = 2'd3; tb_haddr = 32'h048;
    step();
    beat_data(2, 32'hC0DE0002, 2'd3, 32'h04C);
    beat_data(3, 32'hC0DE0003, 2'd0, 32'h000);
    chk("burst_idle_ready", 32'(cur_rdy), 32'd1);
    tb_hsel = 1'b0;
    step();

    // Three-wait responder: hready held low blocks acceptance.
    cur = 0;
    xfer(1'b1, 3'd2, 32'h010, 32'h01020304, rd, err, waits);
    chk("w3_pre_waits", 32'(waits), 32'd3);
    tb_force_nready = 1'b1;
    tb_hsel = 1'b1; tb_htrans = 2'd2; tb_hwrite = 1'b0; tb_hsize = 3'd2; tb_haddr = 32'h010;
    step();
    step();
    tb_hsel = 1'b0; tb_htrans = 2'd0; tb_force_nready = 1'b0;
    #1;
    chk("nready_ready", 32'(cur_rdy), 32'd1);
    chk("nready_rdata", cur_rdata, 32'd0);
    step();
    chk("nready_after", 32'(cur_rdy), 32'd1);

    // Reset in the second wait cycle of a write drops it.
    tb_hsel = 1'b1; tb_htrans = 2'd2; tb_hwrite = 1'b1; tb_hsize = 3'd2; tb_haddr = 32'h010;
    step();
    tb_hsel = 1'b0; tb_htrans = 2'd0; tb_hwdata = 32'hDEADBEEF;
    chk("rstw_wait1", 32'(cur_rdy), 32'd0);
    step();
    chk("rstw_wait2", 32'(cur_rdy), 32'd0);
    hreset = 1'b1;
    #1;
    chk("rstw_ready", 32'(cur_rdy), 32'd1);
    chk("rstw_resp", 32'(cur_resp), 32'd0);
    chk("rstw_rdata", cur_rdata, 32'd0);
    step();
    hreset = 1'b0;
    step();
    xfer(1'b0, 3'd2, 32'h010, 32'h0, rd, err, waits);
    chk("rstw_mem", rd, 32'h01020304);
    chk("rstw_read_waits", 32'(waits), 32'd3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
